// File: rtl/kl_sram_responder.sv
// Single-port 64-bit SRAM responder: one outstanding read or write burst, 1-cycle read latency.
// Optional write acknowledge beat enabled by defining KL_SRAM_WRITE_ACK_EN.
module kl_sram_responder #(
  parameter int DEPTH_WIDTH = 10,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  input  logic [2:0]  req_size,
  input  logic [4:0]  req_srcid,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [63:0] resp_rdata,
  output logic [2:0]  resp_size,
  output logic [4:0]  resp_dstid,
  output logic        resp_valid,
  input  logic        resp_ready
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

`ifdef KL_SRAM_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WDATA, RDATA, WACK} state_t;

  localparam state_t WR_DONE = ACK_EN ? WACK : IDLE;

  function automatic logic [3:0] beats_of(input logic [2:0] size);
    logic [3:0] n;
    case (size)
      3'd4:         n = 4'd2;
      3'd5:         n = 4'd4;
      3'd6, 3'd7:   n = 4'd8;
      default:      n = 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic [DEPTH_WIDTH-1:0] align_base(input logic [DEPTH_WIDTH-1:0] idx,
                                                       input logic [3:0]             n);
    return idx & ~(DEPTH_WIDTH'(n) - DEPTH_WIDTH'(1));
  endfunction

  logic [63:0]            mem [DEPTH];
  state_t                 state, state_nxt;
  logic [DEPTH_WIDTH-1:0] idx;
  logic [3:0]             cnt;
  logic [2:0]             size_q;
  logic [4:0]             srcid_q;
  logic [63:0]            rdata_p1;

  logic                   req_fire, resp_fire;
  logic [DEPTH_WIDTH-1:0] cmd_idx, cmd_base;
  logic [3:0]             cmd_n;
  logic                   rd_load, wr_en;
  logic [DEPTH_WIDTH-1:0] rd_addr, wr_addr;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:DEPTH_WIDTH+3], req_addr[2:0]};

  assign cmd_idx   = req_addr[DEPTH_WIDTH+2:3];
  assign cmd_n     = beats_of(req_size);
  assign cmd_base  = align_base(cmd_idx, cmd_n);
  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;

  // A single-beat write lands at the command edge; burst beats land at the running index.
  assign wr_en   = ((state == IDLE) && req_fire && req_wen && (cmd_n == 4'd1)) ||
                   ((state == WDATA) && req_fire);
  assign wr_addr = (state == IDLE) ? cmd_idx : idx;

  // The next word is prefetched on each handshake so rdata stays put while stalled.
  assign rd_load = ((state == IDLE) && req_fire && !req_wen) ||
                   ((state == RDATA) && resp_fire && (cnt != 4'd1));
  assign rd_addr = (state == IDLE) ? cmd_base : idx + DEPTH_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (req_fire) state_nxt = req_wen ? ((cmd_n == 4'd1) ? WR_DONE : WDATA) : RDATA;
      WDATA: if (req_fire && (cnt == 4'd1)) state_nxt = WR_DONE;
      RDATA: if (resp_fire && (cnt == 4'd1)) state_nxt = IDLE;
      WACK:  if (resp_fire || !ACK_EN) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = !rst && ((state == IDLE) || (state == WDATA));
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_size  = '0;
    resp_dstid = '0;
    unique case (state)
      RDATA: begin
        resp_valid = !rst;
        resp_rdata = rdata_p1;
        resp_size  = size_q;
        resp_dstid = srcid_q;
      end
      WACK: begin
        resp_valid = !rst && ACK_EN;
        resp_size  = 3'd3;
        resp_dstid = srcid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_fire) begin
          idx <= cmd_base;
          cnt <= cmd_n;
        end
        WDATA: if (req_fire) begin
          idx <= idx + DEPTH_WIDTH'(1);
          cnt <= cnt - 4'd1;
        end
        RDATA: if (resp_fire) begin
          idx <= idx + DEPTH_WIDTH'(1);
          cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered read data and latched response fields
  always_ff @(posedge clk) begin
    if (rd_load) rdata_p1 <= mem[rd_addr];
    if ((state == IDLE) && req_fire) begin
      size_q  <= req_size;
      srcid_q <= req_srcid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wmask[b]) mem[wr_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule
